// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package comparator_pkg;

    // Control FSM: IDLE waits for start, CMP walks the chunks MSB first.
    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // One result register drives the g/e/s flags; RES_NONE only exists
    // between reset and the first completed compare.
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_EQ   = 2'd2,
        RES_LT   = 2'd3
    } result_t;

    // Number of chunks an operand splits into.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index; never narrower than one bit.
    function automatic int calc_idx_w(input int nchunk);
        if (nchunk > 1) begin
            return $clog2(nchunk);
        end
        return 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// Combinational unsigned compare of one chunk pair. invert_msb_i flips the
// top bit of both chunks so a two's-complement sign chunk orders correctly.
module chunk_compare #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             invert_msb_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    logic [CHUNK-1:0] flip_mask;
    logic [CHUNK-1:0] a_adj;
    logic [CHUNK-1:0] b_adj;

    // Offset-binary conversion of the sign chunk, then a plain unsigned compare.
    always_comb begin
        flip_mask = CHUNK'(invert_msb_i) << (CHUNK - 1);
        a_adj     = a_i ^ flip_mask;
        b_adj     = b_i ^ flip_mask;
        gt_o      = (a_adj > b_adj);
        eq_o      = (a_adj == b_adj);
        lt_o      = (a_adj < b_adj);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares CHUNK bits per cycle, MSB chunk
// first, and finishes on the first differing chunk or after the last chunk.
//
// Handshake: start is sampled only while busy=0 (including the done cycle,
// so back-to-back operations are allowed); a, b and signed_mode are captured
// on that edge. busy is high for every compare cycle; done pulses for one
// cycle when g/e/s have just been updated. g/e/s hold until the next done.
module seq_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             s,
    output logic             state_dbg
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam int NSLOT  = 1 << IDX_W;

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_cfg
            $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    result_t          res_q, res_d;
    logic             done_q, done_d;

    // Chunk mux padded to a power of two so idx_q indexes it without range gaps.
    logic [CHUNK-1:0] a_slot [NSLOT];
    logic [CHUNK-1:0] b_slot [NSLOT];

    generate
        for (genvar i = 0; i < NSLOT; i++) begin : g_slot
            if (i < NCHUNK) begin : g_real
                assign a_slot[i] = a_q[i*CHUNK +: CHUNK];
                assign b_slot[i] = b_q[i*CHUNK +: CHUNK];
            end else begin : g_pad
                assign a_slot[i] = '0;
                assign b_slot[i] = '0;
            end
        end
    endgenerate

    logic cmp_gt, cmp_eq, cmp_lt;
    logic invert_msb;
    logic last_chunk;

    assign invert_msb = sm_q && (idx_q == IDX_W'(NCHUNK - 1));
    assign last_chunk = (idx_q == '0);

    chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
        .a_i          (a_slot[idx_q]),
        .b_i          (b_slot[idx_q]),
        .invert_msb_i (invert_msb),
        .gt_o         (cmp_gt),
        .eq_o         (cmp_eq),
        .lt_o         (cmp_lt)
    );

    // State, captured operands, chunk index, result and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    // Next-state: capture on start in IDLE, step down through chunks in CMP.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        idx_d   = idx_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CMP;
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    idx_d   = IDX_W'(NCHUNK - 1);
                end
            end
            CMP: begin
                if (!cmp_eq || last_chunk) begin
                    if (cmp_gt) begin
                        res_d = RES_GT;
                    end else if (cmp_lt) begin
                        res_d = RES_LT;
                    end else begin
                        res_d = RES_EQ;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == CMP);
    assign done      = done_q;
    assign g         = (res_q == RES_GT);
    assign e         = (res_q == RES_EQ);
    assign s         = (res_q == RES_LT);
    assign state_dbg = state_q;

endmodule
